// File: rtl/sfx_pkg.sv
// Shared types, effect ranking and the constant note table for the sound-effect sequencer.
package sfx_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        JUMP  = 2'd1,
        DEATH = 2'd2,
        WIN   = 2'd3
    } sfx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    typedef struct packed {
        logic [16:0] halfPeriod;   // clk cycles per half square-wave period, 0 = rest
        logic [9:0]  durationMs;   // note length in ms ticks
        logic        last;         // final note of the effect
    } note_t;

    localparam int MAX_NOTES = 4;

    // NOTE: the note table is pure combinational ROM decoded from constants, so it has no reset.
    function automatic note_t get_note(input sfx_e sfx, input logic [1:0] idx);
        note_t n;
        n = '{halfPeriod: 17'd0, durationMs: 10'd1, last: 1'b1};
        case ({sfx, idx})
            {JUMP,  2'd0}: n = '{17'd14261, 10'd60,  1'b0};
            {JUMP,  2'd1}: n = '{17'd10684, 10'd60,  1'b1};
            {DEATH, 2'd0}: n = '{17'd28523, 10'd150, 1'b0};
            {DEATH, 2'd1}: n = '{17'd38030, 10'd150, 1'b0};
            {DEATH, 2'd2}: n = '{17'd57045, 10'd200, 1'b1};
            {WIN,   2'd0}: n = '{17'd23985, 10'd100, 1'b0};
            {WIN,   2'd1}: n = '{17'd19037, 10'd100, 1'b0};
            {WIN,   2'd2}: n = '{17'd16008, 10'd100, 1'b0};
            {WIN,   2'd3}: n = '{17'd11992, 10'd200, 1'b1};
            default:       n = '{halfPeriod: 17'd0, durationMs: 10'd1, last: 1'b1};
        endcase
        return n;
    endfunction

    // Arbitration rank: DEATH beats WIN beats JUMP; NONE ranks lowest.
    function automatic logic [1:0] sfxRank(input sfx_e sfx);
        logic [1:0] r;
        case (sfx)
            JUMP:    r = 2'd1;
            WIN:     r = 2'd2;
            DEATH:   r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Pending vector is indexed by effect code: [1] JUMP, [2] DEATH, [3] WIN.
    function automatic sfx_e pickHighest(input logic [3:1] pending);
        sfx_e s;
        if (pending[2])      s = DEATH;
        else if (pending[3]) s = WIN;
        else if (pending[1]) s = JUMP;
        else                 s = NONE;
        return s;
    endfunction

    function automatic logic [3:1] sfxMask(input sfx_e sfx);
        logic [3:1] m;
        case (sfx)
            JUMP:    m = 3'b001;
            DEATH:   m = 3'b010;
            WIN:     m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: counts half periods and toggles the tone on each wrap.
module sfx_tone_gen (
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear,       // silence and park the counter
    input  logic        load,        // start a new note: restart count, tone high unless rest
    input  logic        enable,      // advance the waveform by one clk
    input  logic [16:0] halfPeriod,
    output logic        toneOut
);

    logic [16:0] halfCount;

    // Half-period counter and output toggle.
    // NOTE: sequential state uses <= so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            halfCount <= '0;
            toneOut   <= 1'b0;
        end else if (clear) begin
            halfCount <= '0;
            toneOut   <= 1'b0;
        end else if (load) begin
            halfCount <= '0;
            toneOut   <= (halfPeriod != 17'd0);
        end else if (enable) begin
            if (halfPeriod == 17'd0) begin
                halfCount <= '0;
                toneOut   <= 1'b0;
            end else if (halfCount == halfPeriod - 17'd1) begin
                halfCount <= '0;
                toneOut   <= ~toneOut;
            end else begin
                halfCount <= halfCount + 17'd1;
            end
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Game-event sound sequencer: edge-detects event lines, arbitrates pending
// requests by priority and steps through the selected effect's note table.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV   = 25100,  // clk cycles per 1 ms tick
    parameter int TONE_SHIFT = 0       // half-periods divided by 2**TONE_SHIFT; 0 = table pitch
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       eventJump,
    input  logic       eventDeath,
    input  logic       eventWin,
    input  logic       mute,
    output logic       soundOut,
    output logic       busy,
    output logic [1:0] activeSfx
);

    localparam logic [14:0] TICK_LAST = 15'(TICK_DIV - 1);

    state_e      state, stateNext;
    sfx_e        activeReg, activeNext, best;
    logic [$clog2(MAX_NOTES)-1:0] noteIdx, noteIdxNext;
    logic [3:1]  evNow, prevEv, rise, pending, pendClr;
    logic [14:0] msPrescale;
    logic [9:0]  msCount;
    note_t       note;
    logic        tickWrap, noteDone;
    logic        toneLoad, toneEn, toneClr, timerClr, timerEn, toneOut;

    assign evNow    = {eventWin, eventDeath, eventJump};
    assign rise     = evNow & ~prevEv;
    assign best     = pickHighest(pending);
    assign note     = get_note(activeReg, noteIdx);
    assign tickWrap = (msPrescale == TICK_LAST);
    assign noteDone = tickWrap && (msCount + 10'd1 == note.durationMs);

    // Edge detectors and pending latches; prev resets high so a line held through reset is ignored.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prevEv  <= 3'b111;
            pending <= '0;
        end else begin
            prevEv  <= evNow;
            pending <= (pending & ~pendClr) | rise;
        end
    end

    // FSM state, current effect and note index.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            activeReg <= NONE;
            noteIdx   <= '0;
        end else begin
            state     <= stateNext;
            activeReg <= activeNext;
            noteIdx   <= noteIdxNext;
        end
    end

    // Next state, arbitration/preemption and control strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no branch leaves one unassigned and no latch is inferred.
        stateNext   = state;
        activeNext  = activeReg;
        noteIdxNext = noteIdx;
        pendClr     = '0;
        toneLoad    = 1'b0;
        toneEn      = 1'b0;
        toneClr     = 1'b0;
        timerClr    = 1'b0;
        timerEn     = 1'b0;
        unique case (state)
            IDLE: begin
                if (best != NONE) begin
                    activeNext  = best;
                    noteIdxNext = '0;
                    pendClr     = sfxMask(best);
                    stateNext   = LOAD;
                end
            end
            LOAD, PLAY: begin
                if (sfxRank(best) > sfxRank(activeReg)) begin
                    activeNext  = best;
                    noteIdxNext = '0;
                    pendClr     = sfxMask(best);
                    stateNext   = LOAD;
                end else if (state == LOAD) begin
                    toneLoad  = 1'b1;
                    timerClr  = 1'b1;
                    stateNext = PLAY;
                end else begin
                    toneEn  = 1'b1;
                    timerEn = 1'b1;
                    if (noteDone) begin
                        if (note.last) begin
                            activeNext  = NONE;
                            noteIdxNext = '0;
                            toneClr     = 1'b1;
                            timerClr    = 1'b1;
                            stateNext   = IDLE;
                        end else begin
                            noteIdxNext = noteIdx + 2'd1;
                            stateNext   = LOAD;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Millisecond prescaler and per-note ms counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            msPrescale <= '0;
            msCount    <= '0;
        end else if (timerClr) begin
            msPrescale <= '0;
            msCount    <= '0;
        end else if (timerEn) begin
            if (tickWrap) begin
                msPrescale <= '0;
                msCount    <= msCount + 10'd1;
            end else begin
                msPrescale <= msPrescale + 15'd1;
            end
        end
    end

    sfx_tone_gen u_tone (
        .clk        (clk),
        .resetN     (resetN),
        .clear      (toneClr),
        .load       (toneLoad),
        .enable     (toneEn),
        .halfPeriod (note.halfPeriod >> TONE_SHIFT),
        .toneOut    (toneOut)
    );

    assign soundOut  = toneOut & ~mute;
    assign busy      = (state != IDLE);
    assign activeSfx = activeReg;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: per-cycle comparison against a
// note-position model, plus hand-computed timing literals.
module tb_sfx_sequencer;

    localparam int TICK  = 20;   // ms tick in clk cycles for this build
    localparam int SHIFT = 9;    // half-periods divided by 512

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       eventJump = 1'b0, eventDeath = 1'b0, eventWin = 1'b0, mute = 1'b0;
    logic       soundOut, busy;
    logic [1:0] activeSfx;

    sfx_sequencer #(.TICK_DIV(TICK), .TONE_SHIFT(SHIFT)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .eventJump  (eventJump),
        .eventDeath (eventDeath),
        .eventWin   (eventWin),
        .mute       (mute),
        .soundOut   (soundOut),
        .busy       (busy),
        .activeSfx  (activeSfx)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    bit done    = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Effect table indexed [effect code][note]: 1 JUMP, 2 DEATH, 3 WIN.
    int halfFull [1:3][0:3] = '{'{14261, 10684, 0, 0},
                                '{28523, 38030, 57045, 0},
                                '{23985, 19037, 16008, 11992}};
    int durMs    [1:3][0:3] = '{'{60, 60, 0, 0},
                                '{150, 150, 200, 0},
                                '{100, 100, 100, 200}};
    int numNotes [1:3]      = '{2, 3, 4};

    // Model: phase 0 idle, 1 load, 2 play; mPos = cycles elapsed in the PLAY part of the note.
    int mPhase = 0, mSfx = 0, mNote = 0, mPos = 0;
    bit mPend [1:3];
    bit mPrev [1:3];

    function automatic int rank(input int s);
        case (s)
            1: return 1;
            3: return 2;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic modelStep();
        bit ev [1:3];
        int order [3];
        int best, clr;
        ev[1] = eventJump; ev[2] = eventDeath; ev[3] = eventWin;
        if (!resetN) begin
            mPhase = 0; mSfx = 0; mNote = 0; mPos = 0;
            for (int s = 1; s <= 3; s++) begin mPend[s] = 0; mPrev[s] = 1; end
            return;
        end
        order = '{2, 3, 1};
        best = 0;
        for (int k = 0; k < 3; k++) if (best == 0 && mPend[order[k]]) best = order[k];
        clr = 0;
        if (mPhase == 0) begin
            if (best != 0) begin mSfx = best; mNote = 0; clr = best; mPhase = 1; end
        end else if (rank(best) > rank(mSfx)) begin
            mSfx = best; mNote = 0; clr = best; mPhase = 1;
        end else if (mPhase == 1) begin
            mPhase = 2; mPos = 0;
        end else begin
            mPos++;
            if (mPos == durMs[mSfx][mNote] * TICK) begin
                if (mNote == numNotes[mSfx] - 1) begin mPhase = 0; mSfx = 0; end
                else begin mNote++; mPhase = 1; end
            end
        end
        for (int s = 1; s <= 3; s++) begin
            if (clr == s) mPend[s] = 0;
            if (ev[s] && !mPrev[s]) mPend[s] = 1;
            mPrev[s] = ev[s];
        end
    endtask

    function automatic int expSound();
        int hp;
        if (mPhase != 2 || mute) return 0;
        hp = halfFull[mSfx][mNote] >> SHIFT;
        if (hp == 0) return 0;
        return ((mPos / hp) % 2 == 0) ? 1 : 0;
    endfunction

    // Per-cycle compare: outputs sampled 1 ns after each rising edge.
    initial begin
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            modelStep();
            check($sformatf("busy@%0d", cyc), busy, (mPhase != 0) ? 1 : 0);
            check($sformatf("activeSfx@%0d", cyc), activeSfx, mSfx);
            if (mPhase != 1) check($sformatf("soundOut@%0d", cyc), soundOut, expSound());
        end
    end

    task automatic edgeWait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts rising edges until busy is seen low; an expired bound is a failure.
    task automatic waitBusyLow(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("busy-low timeout", 1, 0);
    endtask

    // Pulses one or more event lines for one sample, then measures busy and tone activity.
    task automatic playMeasured(input bit j, input bit d, input bit w,
                                output int busyCycles, output int soundCycles);
        int n;
        @(negedge clk);
        eventJump = j; eventDeath = d; eventWin = w;
        @(negedge clk);
        eventJump = 0; eventDeath = 0; eventWin = 0;
        busyCycles = 0; soundCycles = 0; n = 0;
        #6;  // now 1 ns after E1
        while (busy && n < 20000) begin
            busyCycles++;
            if (soundOut) soundCycles++;
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("measure timeout", 1, 0);
    endtask

    initial begin
        int n, bHi, sHi;

        // Reset with eventJump held high: no request may appear.
        eventJump = 1;
        #1 resetN = 0;
        #2;
        check("reset soundOut", soundOut, 0);
        check("reset busy", busy, 0);
        check("reset activeSfx", activeSfx, 0);
        repeat (3) @(negedge clk);
        resetN = 1;
        edgeWait(1000);
        check("held-through-reset busy", busy, 0);
        @(negedge clk);
        eventJump = 0;
        edgeWait(5);

        // JUMP: half periods 14261>>9 = 27 and 10684>>9 = 20; notes 1 + 60*20 = 1201 cycles each.
        @(negedge clk);
        eventJump = 1;
        @(posedge clk);                  // E0
        @(negedge clk);
        eventJump = 0;
        edgeWait(1);                     // E1
        check("jump E1 busy", busy, 1);
        check("jump E1 activeSfx", activeSfx, 1);
        edgeWait(1);                     // E2
        check("jump E2 soundOut", soundOut, 1);
        edgeWait(26);                    // E2+26
        check("jump before first toggle", soundOut, 1);
        edgeWait(1);                     // E2+27
        check("jump first toggle", soundOut, 0);
        edgeWait(27);                    // E2+54
        check("jump second toggle", soundOut, 1);
        // busy falls at E1 + 2*1201 = E2 + 2401; we are at E2+54.
        waitBusyLow(5000, n);
        check("jump busy length", n, 2401 - 54);
        edgeWait(5);

        // WIN preempts JUMP during its second note (which plays E0+1203 .. E0+2402).
        @(negedge clk);
        eventJump = 1;
        @(negedge clk);
        eventJump = 0;
        edgeWait(1300);
        @(negedge clk);
        eventWin = 1;
        @(posedge clk);                  // Ek
        @(negedge clk);
        eventWin = 0;
        edgeWait(1);                     // Ek+1: LOAD of WIN
        check("preempt activeSfx", activeSfx, 3);
        edgeWait(1);                     // Ek+2
        check("preempt tone start", soundOut, 1);
        edgeWait(45);                    // Ek+47, half period 23985>>9 = 46
        check("preempt before toggle", soundOut, 1);
        edgeWait(1);
        check("preempt toggle", soundOut, 0);
        // WIN: 2001*3 + 4001 = 10004 cycles from Ek+1; we are at Ek+48.
        waitBusyLow(12000, n);
        check("preempt win length", n, 10004 - 47);
        edgeWait(5);
        check("jump not resumed", activeSfx, 0);

        // Simultaneous JUMP and DEATH: DEATH first (3001+3001+4001 = 10003 cycles), gap, then JUMP.
        @(negedge clk);
        eventJump = 1; eventDeath = 1;
        @(negedge clk);
        eventJump = 0; eventDeath = 0;
        edgeWait(1);                     // E1
        check("simul first effect", activeSfx, 2);
        n = 0;
        while (activeSfx == 2 && n < 12000) begin
            edgeWait(1);
            n++;
        end
        check("death length", n, 10003);
        check("gap activeSfx", activeSfx, 0);
        check("gap busy", busy, 0);
        edgeWait(1);
        check("jump after death", activeSfx, 1);
        check("jump after death busy", busy, 1);
        waitBusyLow(5000, n);
        edgeWait(5);

        // WIN unmuted then muted: same busy length, no tone while muted.
        playMeasured(0, 0, 1, bHi, sHi);
        check("win busy cycles", bHi, 10004);
        check("win tone present", (sHi > 0) ? 1 : 0, 1);
        edgeWait(3);
        @(negedge clk);
        mute = 1;
        playMeasured(0, 0, 1, bHi, sHi);
        check("muted win busy cycles", bHi, 10004);
        check("muted win tone cycles", sHi, 0);
        @(negedge clk);
        mute = 0;
        edgeWait(3);

        // Reset in the middle of DEATH, while the tone is high.
        @(negedge clk);
        eventDeath = 1;
        @(negedge clk);
        eventDeath = 0;
        edgeWait(500);
        n = 0;
        while (!soundOut && n < 200) begin
            edgeWait(1);
            n++;
        end
        check("death tone high before reset", soundOut, 1);
        #2 resetN = 0;
        #1;
        check("async reset soundOut", soundOut, 0);
        check("async reset busy", busy, 0);
        check("async reset activeSfx", activeSfx, 0);
        repeat (3) @(negedge clk);
        resetN = 1;
        edgeWait(300);
        check("no resume busy", busy, 0);
        check("no resume activeSfx", activeSfx, 0);

        done = 1;
        edgeWait(2);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
